// File: rtl/pulse_seq_pkg.sv
// Shared state encoding and default timing constants for the pulse sequence arbiter.
package pulse_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned ARM_CYCLES_DEF = 2;
    localparam int unsigned WDOG_LIMIT_DEF = 15;

endpackage

// File: rtl/pulse_seq_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  pick_oh_c,
    output logic [IDX_W-1:0] pick_idx_c,
    output logic             pick_vld_c
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        pick_oh_c  = '0;
        pick_idx_c = '0;
        pick_vld_c = 1'b0;
        pos        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = IDX_W'((32'(ptr_i) + k) % NREQ);
            if (!pick_vld_c && req_i[pos]) begin
                pick_vld_c     = 1'b1;
                pick_idx_c     = pos;
                pick_oh_c[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_seq_arbiter.sv
// Round-robin arbiter running an IDLE->ARM->FIRE->DONE pulse sequence per grant.
// Optional watchdog abort with sticky err is enabled by defining WATCHDOG_EN.
module pulse_seq_arbiter
    import pulse_seq_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ARM_CYCLES = ARM_CYCLES_DEF,
    parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    input  logic            err_clr,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic [1:0]      state,
    output logic            out,
    output logic            busy,
    output logic            err
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned ARM_W = $clog2(ARM_CYCLES + 1);

    if (WDOG_LIMIT <= ARM_CYCLES) begin : g_cfg_chk
        $error("pulse_seq_arbiter: WDOG_LIMIT must exceed ARM_CYCLES");
    end

    state_e           state_q, state_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] gidx_next_c;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             wdog_trip_c;

    logic [NREQ-1:0]  pick_oh_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic             pick_vld_c;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .pick_oh_c  (pick_oh_c),
        .pick_idx_c (pick_idx_c),
        .pick_vld_c (pick_vld_c)
    );

    assign gidx_next_c = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arm_cnt_q <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, arm counter and round-robin pointer
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                arm_cnt_d = '0;
                if (pick_vld_c) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!hold) begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                    if (arm_cnt_d == ARM_W'(ARM_CYCLES)) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                state_d = DONE;
                ptr_d   = gidx_next_c;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        // A watchdog abort overrides any normal transition
        if (wdog_trip_c) begin
            state_d = IDLE;
            ptr_d   = gidx_next_c;
        end
    end

    // Next values of the registered outputs
    always_comb begin
        gnt_d  = gnt_q;
        gidx_d = gidx_q;
        done_d = '0;
        if (state_q == IDLE && state_d == ARM) begin
            gnt_d  = pick_oh_c;
            gidx_d = pick_idx_c;
        end
        if (state_d == IDLE) begin
            gnt_d = '0;
        end
        if (state_q == FIRE && state_d == DONE) begin
            done_d = gnt_q;
        end
        out_d  = (state_d == FIRE);
        busy_d = (state_d != IDLE);
    end

`ifdef WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;

    // wdog_q counts cycles already spent in the current non-IDLE state
    assign wdog_trip_c = (state_q != IDLE) && (wdog_q == WD_W'(WDOG_LIMIT - 1));

    always_comb begin
        wdog_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            wdog_d = wdog_q + WD_W'(1);
        end
        err_d = err_q;
        if (wdog_trip_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;

    assign wdog_trip_c    = 1'b0;
    assign err            = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign state = state_q;
    assign out   = out_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_pulse_seq_arbiter.sv
// Directed plus random bench for pulse_seq_arbiter against a stage-count reference model.
module tb_pulse_seq_arbiter;

    localparam int NREQ       = 4;
    localparam int ARM_CYCLES = 2;
    localparam int WDOG_LIMIT = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            hold;
    logic            err_clr;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [1:0]      state;
    logic            out;
    logic            busy;
    logic            err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner index, progress through the sequence, time spent in ARM
    int m_owner    = -1;
    int m_stage    = 0;
    int m_arm_time = 0;
    int m_ptr      = 0;
    bit m_err      = 1'b0;

    pulse_seq_arbiter #(
        .NREQ       (NREQ),
        .ARM_CYCLES (ARM_CYCLES),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .hold    (hold),
        .err_clr (err_clr),
        .gnt     (gnt),
        .done    (done),
        .state   (state),
        .out     (out),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
`ifdef WATCHDOG_EN
        bit set_err = 1'b0;
`endif
        if (rst) begin
            m_owner    = -1;
            m_stage    = 0;
            m_arm_time = 0;
            m_ptr      = 0;
            m_err      = 1'b0;
        end else begin
            if (m_owner >= 0) begin
                if (m_stage < ARM_CYCLES) begin
                    m_arm_time++;
                    if (!hold) m_stage++;
`ifdef WATCHDOG_EN
                    if (m_arm_time >= WDOG_LIMIT) begin
                        set_err = 1'b1;
                        m_ptr   = (m_owner + 1) % NREQ;
                        m_owner = -1;
                    end
`endif
                end else if (m_stage == ARM_CYCLES) begin
                    m_stage++;
                    m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    m_owner = -1;
                end
            end else if (req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
                end
                m_stage    = 0;
                m_arm_time = 0;
            end
`ifdef WATCHDOG_EN
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
`endif
        end
    endtask

    task automatic check_all();
        logic [1:0]      es;
        logic [NREQ-1:0] eg;
        if (m_owner < 0) es = 2'd0;
        else if (m_stage < ARM_CYCLES) es = 2'd1;
        else if (m_stage == ARM_CYCLES) es = 2'd2;
        else es = 2'd3;
        eg = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
        chk("state", 32'(state), 32'(es));
        chk("gnt", 32'(gnt), 32'(eg));
        chk("done", 32'(done), (es == 2'd3) ? 32'(eg) : 32'd0);
        chk("out", 32'(out), 32'(es == 2'd2));
        chk("busy", 32'(busy), 32'(es != 2'd0));
        chk("err", 32'(err), 32'(m_err));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        int lat;
        rst = 1'b1; req = '0; hold = 1'b0; err_clr = 1'b0;
        #1;

        // Reset for two cycles, then quiet until the request
        step(); step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        step(); step();

        // Single request: two ARM cycles, one FIRE, one DONE
        req = 4'b0001; step();
        chk("a_gnt", 32'(gnt), 32'h1);
        chk("a_arm0", 32'(state), 32'd1);
        req = '0; step();
        chk("a_arm1", 32'(state), 32'd1);
        step();
        chk("a_fire", 32'(state), 32'd2);
        chk("a_out", 32'(out), 32'd1);
        step();
        chk("a_done", 32'(done), 32'h1);
        chk("a_done_out", 32'(out), 32'd0);
        step();
        chk("a_idle", 32'(state), 32'd0);
        chk("a_idle_gnt", 32'(gnt), 32'd0);

        // All requesting: grants rotate 0,1,2,3,0 every ARM_CYCLES+3 cycles
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(1 << (g % NREQ)));
            for (int c = 0; c < ARM_CYCLES + 2; c++) step();
        end
        req = '0;
        step();

        // Hold in ARM for 4 cycles delays FIRE by 4
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0001; step();
        req = '0; hold = 1'b1;
        for (int i = 0; i < 4; i++) step();
        hold = 1'b0;
        lat = 4;
        for (int i = 0; i < 20; i++) begin
            if (out === 1'b1) break;
            step();
            lat++;
        end
        chk("hold_fire_lat", 32'(lat), 32'(ARM_CYCLES + 4));
        chk("hold_err", 32'(err), 32'd0);
        step(); step();

        // Long hold: watchdog abort when enabled, indefinite stall otherwise
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0001; step();
        req = '0; hold = 1'b1;
`ifdef WATCHDOG_EN
        for (int i = 1; i < WDOG_LIMIT; i++) step();
        chk("wd_still_arm", 32'(state), 32'd1);
        step();
        chk("wd_idle", 32'(state), 32'd0);
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_gnt", 32'(gnt), 32'd0);
        for (int i = 0; i < 20 - WDOG_LIMIT; i++) step();
        hold = 1'b0; err_clr = 1'b1; step();
        chk("wd_clr", 32'(err), 32'd0);
        err_clr = 1'b0;
`else
        for (int i = 0; i < 20; i++) step();
        chk("stall_arm", 32'(state), 32'd1);
        chk("stall_err", 32'(err), 32'd0);
        hold = 1'b0;
        for (int i = 0; i < ARM_CYCLES + 2; i++) step();
`endif
        step();

        // Reset during FIRE aborts with no done pulse
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0001; step();
        req = '0; step(); step();
        chk("f_in_fire", 32'(state), 32'd2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("f_out", 32'(out), 32'd0);
        chk("f_gnt", 32'(gnt), 32'd0);
        chk("f_state", 32'(state), 32'd0);
        chk("f_done", 32'(done), 32'd0);
        step();

        // Grantee drops req mid-sequence; the other waiter is granted next
        req = 4'b0011; step();
        chk("d_gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        step(); step(); step();
        chk("d_done", 32'(done), 32'h1);
        step(); step();
        chk("d_gnt1", 32'(gnt), 32'h2);
        req = '0;
        for (int i = 0; i < ARM_CYCLES + 3; i++) step();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            req     = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom_range(0, 15));
            hold    = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
